// File: rtl/sleepwell_motion_ctrl.sv
// sleepwell_motion_ctrl: once-per-frame ball motion scheduler.
// A frame tick launches a short update: step X, step Y, then report completion.
// Each axis advances by its latched speed, clamps to the active-area limits, and reverses direction at a wall.
// The compositor reads ball_x/ball_y directly, so the position holds still for the whole visible frame.
module sleepwell_motion_ctrl #(
    parameter int BALL_SIZE = 20,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int X_INIT    = 320,
    parameter int Y_INIT    = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic [2:0] speed_x,
    input  logic [2:0] speed_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [7:0] bounce_cnt,
    output logic       busy,
    output logic       update_done,
    output logic       bounce_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP_X,
        S_STEP_Y,
        S_DONE
    } state_t;

    // Limits are 11 bits wide so that (limit + step) and (pos + step) never wrap.
    localparam logic [10:0] LIM_LO   = 11'(BALL_SIZE);
    localparam logic [10:0] LIM_HI_X = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] LIM_HI_Y = 11'(V_ACTIVE - BALL_SIZE);

    state_t      r_state;
    state_t      w_next_state;
    logic [9:0]  r_ball_x;
    logic [9:0]  r_ball_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [2:0]  r_sx;
    logic [2:0]  r_sy;
    logic        r_bf;
    logic [7:0]  r_bounce_cnt;
    logic        w_accept;
    logic [11:0] w_step_x;
    logic [11:0] w_step_y;

    // One axis step. The result packs {bounced, new_dir, new_pos[9:0]}.
    // A zero step holds both position and direction, and it never counts as a bounce.
    function automatic logic [11:0] axis_step(input logic [9:0]  pos,
                                              input logic        dir,
                                              input logic [2:0]  step,
                                              input logic [10:0] lim_hi);
        logic [10:0] pos_w;
        logic [10:0] fwd;
        logic [9:0]  back;
        logic [11:0] res;
        pos_w = {1'b0, pos};
        fwd   = pos_w + {8'b0, step};
        back  = pos - {7'b0, step};
        res   = {1'b0, dir, pos};
        if (step != 3'd0) begin
            if (dir) begin
                if (fwd >= lim_hi) res = {1'b1, 1'b0, lim_hi[9:0]};
                else               res = {1'b0, 1'b1, fwd[9:0]};
            end else begin
                // The wall test is done before subtracting, so the position cannot underflow.
                if (pos_w <= LIM_LO + {8'b0, step}) res = {1'b1, 1'b1, LIM_LO[9:0]};
                else                                 res = {1'b0, 1'b0, back};
            end
        end
        return res;
    endfunction

    assign w_accept = frame_tick && !pause;
    assign w_step_x = axis_step(r_ball_x, r_dir_x, r_sx, LIM_HI_X);
    assign w_step_y = axis_step(r_ball_y, r_dir_y, r_sy, LIM_HI_Y);

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic. Ticks arriving outside IDLE are simply dropped.
    // NOTE: the default assignment at the top keeps this combinational block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_STEP_X;
            S_STEP_X: w_next_state = S_STEP_Y;
            S_STEP_Y: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch the speeds on accept, step each axis in its own state, count bounce frames on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ball_x     <= 10'(X_INIT);
            r_ball_y     <= 10'(Y_INIT);
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b1;
            r_sx         <= 3'd0;
            r_sy         <= 3'd0;
            r_bf         <= 1'b0;
            r_bounce_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sx <= speed_x;
                        r_sy <= speed_y;
                        r_bf <= 1'b0;
                    end
                end
                S_STEP_X: begin
                    r_ball_x <= w_step_x[9:0];
                    r_dir_x  <= w_step_x[10];
                    if (w_step_x[11]) r_bf <= 1'b1;
                end
                S_STEP_Y: begin
                    r_ball_y <= w_step_y[9:0];
                    r_dir_y  <= w_step_y[10];
                    if (w_step_y[11]) r_bf <= 1'b1;
                end
                S_DONE: begin
                    // A frame that bounces on both axes (a corner hit) still counts only once.
                    if (r_bf && (r_bounce_cnt != 8'hFF)) r_bounce_cnt <= r_bounce_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Output decode, driven only by the current state and the registered flags.
    always_comb begin
        busy         = (r_state != S_IDLE);
        update_done  = (r_state == S_DONE);
        bounce_pulse = (r_state == S_DONE) && r_bf;
    end

    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;
    assign dir_x      = r_dir_x;
    assign dir_y      = r_dir_y;
    assign bounce_cnt = r_bounce_cnt;

endmodule

// File: doc/sleepwell_motion_ctrl.md
# sleepwell_motion_ctrl

Per-frame motion scheduler for the bouncing-ball renderer. Once per video frame it advances the ball centre by a programmable step, reflects and clamps at the active-area edges, and counts wall bounces. It sits between the sync generator (frame strobe) and the pixel compositor, which consumes `ball_x`/`ball_y` combinationally. All position updates complete within 4 clocks, well inside vertical blanking.

## Interface

Parameters:

- `BALL_SIZE`, 20: ball radius in pixels. Sets the reflection limits.
- `H_ACTIVE`, 640: active width.
- `V_ACTIVE`, 480: active height.
- `X_INIT`, 320: reset x centre.
- `Y_INIT`, 240: reset y centre.

Ports:

- `clk`  in  1  pixel clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse at hpos==0, vpos==0.
- `pause`  in  1  while high, `frame_tick` is ignored.
- `speed_x`  in  3  x step, 0..7 px/frame.
- `speed_y`  in  3  y step, 0..7 px/frame.
- `ball_x`  out  10  ball centre x (registered).
- `ball_y`  out  10  ball centre y (registered).
- `dir_x`  out  1  1 = moving right, 0 = moving left.
- `dir_y`  out  1  1 = moving down, 0 = moving up.
- `bounce_cnt`  out  8  frames containing at least one bounce. Saturates at 255.
- `busy`  out  1  high when state != IDLE.
- `update_done`  out  1  high for one cycle when state == DONE.
- `bounce_pulse`  out  1  high with `update_done` if this frame bounced.

## Operation

- The FSM has four states: IDLE, STEP_X, STEP_Y, DONE.
- **IDLE**:
  - If `frame_tick && !pause`: latch `speed_x`/`speed_y` into `sx`/`sy`, clear the bounce flag `bf`, and go to STEP_X.
  - Otherwise stay in IDLE.
- **STEP_X**:
  - Limits: LO = `BALL_SIZE`, HI = `H_ACTIVE - BALL_SIZE`.
  - Arithmetic is 11-bit unsigned, so subtraction never wraps.
  - `sx == 0`: hold `ball_x` and `dir_x`. No bounce.
  - `dir_x = 1`, `sx != 0`: compute `nx = ball_x + sx`.
    - If `nx >= HI`: set `ball_x = HI`, `dir_x = 0`, `bf = 1`.
    - Otherwise: `ball_x = nx`.
  - `dir_x = 0`, `sx != 0`:
    - If `ball_x <= LO + sx`: set `ball_x = LO`, `dir_x = 1`, `bf = 1`.
    - Otherwise: `ball_x = ball_x - sx`.
  - Then go to STEP_Y.
- **STEP_Y**: identical rules using `sy`, `ball_y`, `dir_y`, with HI = `V_ACTIVE - BALL_SIZE`. Then go to DONE.
- **DONE**:
  - `update_done` = 1 and `bounce_pulse` = `bf`.
  - On exit, `bounce_cnt` increments by 1 if `bf` (saturating at 255).
  - A corner hit (x and y both bounce) counts once.
  - Then go to IDLE.
- Resulting ranges: x stays within 20..620 and y within 20..460 at all times after reset.
- `frame_tick` in any state other than IDLE is dropped. It is not queued.
- `pause` is sampled only in IDLE. Asserting it mid-update does not abort the update.
- `speed_*` inputs are sampled only at acceptance. Changes mid-update have no effect.

## Timing

- Reset (async assert, sync release): `ball_x` = X_INIT, `ball_y` = Y_INIT, `dir_x` = `dir_y` = 1, `bounce_cnt` = 0, `busy` = 0, `update_done` = 0, `bounce_pulse` = 0, state = IDLE, `sx` = `sy` = 0, `bf` = 0.
- Edge-by-edge for a `frame_tick` accepted at edge N:
  - Edge N: IDLE→STEP_X; `busy` goes high.
  - Edge N+1: new `ball_x`/`dir_x` visible.
  - Edge N+2: new `ball_y`/`dir_y` visible; enter DONE.
  - Cycle N+2..N+3: `update_done` and `bounce_pulse` are high.
  - Edge N+3: `bounce_cnt` updated; return to IDLE; `busy` low.
- The earliest next acceptance is edge N+4.
- Reset asserted mid-update: all registers return to reset values immediately. No `update_done` is produced.
- Outputs are stable from edge N+3 until the next accepted tick. The compositor sees a full frame with constant position.

## Test plan

- **Reset:** assert `rst_n` = 0 asynchronously mid-cycle → `ball_x` = 320, `ball_y` = 240, `dir_x` = `dir_y` = 1, `bounce_cnt` = 0, `busy` = 0, all without a clock edge.
- **Normal step:** `speed_x` = 2, `speed_y` = 2, one tick → `ball_x` = 322 after N+1, `ball_y` = 242 after N+2, `update_done` high exactly one cycle, `bounce_pulse` = 0, `bounce_cnt` = 0.
- **Right-wall clamp:** start `ball_x` = 618, `dir_x` = 1, `speed_x` = 4 → `ball_x` = 620, `dir_x` = 0, `bounce_pulse` = 1, `bounce_cnt` = 1. Next tick → `ball_x` = 616.
- **Left underflow guard:** start `ball_x` = 22, `dir_x` = 0, `speed_x` = 7 → `ball_x` = 20 (no wrap to ~1015), `dir_x` = 1.
- **Corner and saturation:** x and y both hit limits in one frame → `bounce_cnt` +1 only. Then 300 bouncing frames → `bounce_cnt` holds 255.
- **Pause, busy-drop and speed 0:**
  - `pause` = 1 with a tick → no state change and no `update_done`.
  - A second tick at edge N+2 → ignored; exactly one update occurs.
  - `speed_x` = 0 at `ball_x` = 620 → position and `dir_x` unchanged, no bounce.
